// File: rtl/base_arrmux.sv
// Round-robin arbiter merging `ways` valid/ready streams into one registered
// output stream, with optional packet-level grant hold and source index.
module base_arrmux #(
  parameter int ways        = 2,
  parameter int width       = 1,
  parameter bit pkt         = 1'b0,
  parameter bit reset_ready = 1'b0,
  localparam int sw         = (ways > 2) ? $clog2(ways) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ways-1]       i_v,
  output logic [0:ways-1]       i_r,
  input  logic [0:ways*width-1] i_d,
  input  logic [0:ways-1]       i_e,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [0:width-1]      o_d,
  output logic                  o_e,
  output logic [0:sw-1]         o_s
);

  logic [sw-1:0]    ptr;
  logic             lock;
  logic [sw-1:0]    lock_id;

  logic [0:ways-1]  grant;
  logic [sw-1:0]    gnt_id;
  logic             found;
  logic [sw:0]      sum;
  logic [sw-1:0]    idx;

  logic             space;
  logic             rdy_en;
  logic             accept;
  logic             acc_e;
  logic [0:width-1] acc_d;
  logic [sw-1:0]    nxt_ptr;

  // Locked grants ignore i_v so an idle mid-packet requester keeps the channel.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    if (lock) begin
      grant[lock_id] = 1'b1;
      gnt_id         = lock_id;
    end else begin
      for (int off = 0; off < ways; off++) begin
        sum = {1'b0, ptr} + (sw+1)'(off);
        if (sum >= (sw+1)'(ways)) begin
          sum = sum - (sw+1)'(ways);
        end
        idx = sum[sw-1:0];
        if (!found && i_v[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_id     = idx;
        end
      end
    end
  end

  assign space  = ~o_v | o_r;
  assign rdy_en = space & ~(reset_ready && reset);
  assign i_r    = grant & {ways{rdy_en}};
  assign accept = |(i_v & i_r);
  assign acc_e  = i_e[gnt_id];

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < ways; k++) begin
      if (grant[k]) begin
        acc_d = i_d[k*width +: width];
      end
    end
  end

  assign nxt_ptr = (gnt_id == sw'(ways - 1)) ? '0 : gnt_id + sw'(1);

  // output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      o_v     <= 1'b0;
      o_d     <= '0;
      o_e     <= 1'b0;
      o_s     <= '0;
      ptr     <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      o_v <= 1'b1;
      o_d <= acc_d;
      o_e <= acc_e;
      o_s <= gnt_id;
      if (!pkt || acc_e) begin
        lock <= 1'b0;
        ptr  <= nxt_ptr;
      end else begin
        lock    <= 1'b1;
        lock_id <= gnt_id;
      end
    end else if (o_r) begin
      o_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_base_arrmux.sv
// Bench for base_arrmux: a 4-way per-beat instance and a 3-way packet-mode
// instance, both checked every cycle against a behavioural arbitration model.
module tb_base_arrmux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_ov, a_or, a_oe;
  logic [0:3]  a_iv, a_ir, a_ie;
  logic [0:31] a_id;
  logic [0:7]  a_od;
  logic [0:1]  a_os;

  logic        b_reset, b_ov, b_or, b_oe;
  logic [0:2]  b_iv, b_ir, b_ie;
  logic [0:23] b_id;
  logic [0:7]  b_od;
  logic [0:1]  b_os;

  base_arrmux #(.ways(4), .width(8), .pkt(1'b0), .reset_ready(1'b0)) dut_a (
    .clk(clk), .reset(a_reset), .i_v(a_iv), .i_r(a_ir), .i_d(a_id), .i_e(a_ie),
    .o_v(a_ov), .o_r(a_or), .o_d(a_od), .o_e(a_oe), .o_s(a_os)
  );

  base_arrmux #(.ways(3), .width(8), .pkt(1'b1), .reset_ready(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .i_v(b_iv), .i_r(b_ir), .i_d(b_id), .i_e(b_ie),
    .o_v(b_ov), .o_r(b_or), .o_d(b_od), .o_e(b_oe), .o_s(b_os)
  );

  int checks = 0;
  int errors = 0;

  int nw[2]   = '{4, 3};
  bit npkt[2] = '{1'b0, 1'b1};
  bit nrr[2]  = '{1'b0, 1'b1};

  // requester-side stimulus, index [instance][way]
  bit         sv[2][16];
  logic [7:0] sd[2][16];
  bit         se[2][16];
  bit         s_or[2];
  bit         s_rst[2];

  // reference model state
  bit         m_ov[2];
  logic [7:0] m_od[2];
  bit         m_oe[2];
  int         m_os[2];
  int         m_ptr[2];
  bit         m_lock[2];
  int         m_lid[2];
  int         last_acc[2];

  function automatic int m_grant(input int w);
    if (m_lock[w]) return m_lid[w];
    for (int off = 0; off < nw[w]; off++) begin
      int k;
      k = (m_ptr[w] + off) % nw[w];
      if (sv[w][k]) return k;
    end
    return -1;
  endfunction

  function automatic int m_ready(input int w);
    int g;
    bit space;
    g = m_grant(w);
    space = !m_ov[w] || s_or[w];
    if (g < 0 || !space || (nrr[w] && s_rst[w])) return -1;
    return g;
  endfunction

  function automatic logic [15:0] read_ir(input int w);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < nw[w]; k++) v[k] = (w == 0) ? a_ir[k] : b_ir[k];
    return v;
  endfunction

  function automatic logic [11:0] read_out(input int w);
    if (w == 0) return {a_ov, a_od, a_oe, a_os};
    return {b_ov, b_od, b_oe, b_os};
  endfunction

  task automatic model_reset(input int w);
    m_ov[w] = 1'b0; m_od[w] = 8'h00; m_oe[w] = 1'b0; m_os[w] = 0;
    m_ptr[w] = 0; m_lock[w] = 1'b0; m_lid[w] = 0;
  endtask

  task automatic drive_all();
    for (int k = 0; k < 4; k++) begin
      a_iv[k] = sv[0][k]; a_ie[k] = se[0][k]; a_id[k*8 +: 8] = sd[0][k];
    end
    for (int k = 0; k < 3; k++) begin
      b_iv[k] = sv[1][k]; b_ie[k] = se[1][k]; b_id[k*8 +: 8] = sd[1][k];
    end
    a_or = s_or[0]; a_reset = s_rst[0];
    b_or = s_or[1]; b_reset = s_rst[1];
  endtask

  // One clock for both instances: ready check before the edge, state check after.
  task automatic cycle(input string tag);
    int r[2];
    int acc;
    logic [15:0] want_ir, got_ir;
    logic [11:0] want_o, got_o;
    drive_all();
    #1;
    for (int w = 0; w < 2; w++) begin
      r[w] = m_ready(w);
      want_ir = '0;
      if (r[w] >= 0) want_ir[r[w]] = 1'b1;
      got_ir = read_ir(w);
      checks++;
      if (got_ir !== want_ir) begin
        errors++;
        $display("FAIL %s ready inst%0d got %h want %h", tag, w, got_ir, want_ir);
      end
    end
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      acc = (r[w] >= 0 && sv[w][r[w]]) ? r[w] : -1;
      if (s_rst[w]) begin
        model_reset(w);
      end else if (acc >= 0) begin
        m_ov[w] = 1'b1; m_od[w] = sd[w][acc]; m_oe[w] = se[w][acc]; m_os[w] = acc;
        if (!npkt[w] || se[w][acc]) begin
          m_lock[w] = 1'b0;
          m_ptr[w] = (acc + 1) % nw[w];
        end else begin
          m_lock[w] = 1'b1;
          m_lid[w] = acc;
        end
      end else if (m_ov[w] && s_or[w]) begin
        m_ov[w] = 1'b0;
      end
      if (acc >= 0) sv[w][acc] = 1'b0;
      last_acc[w] = acc;
    end
    #1;
    for (int w = 0; w < 2; w++) begin
      want_o = {m_ov[w], m_od[w], m_oe[w], 2'(m_os[w])};
      got_o = read_out(w);
      checks++;
      if (got_o !== want_o) begin
        errors++;
        $display("FAIL %s out inst%0d {v,d,e,s} got %h want %h", tag, w, got_o, want_o);
      end
    end
  endtask

  task automatic test_reset();
    s_rst[0] = 1'b1; s_rst[1] = 1'b1; s_or[0] = 1'b1; s_or[1] = 1'b1;
    sv[1][0] = 1'b1; sd[1][0] = 8'h77; se[1][0] = 1'b0;
    drive_all();
    repeat (2) @(posedge clk);
    #1;
    model_reset(0);
    model_reset(1);
    cycle("reset");
    checks++;
    if ({a_ov, a_od, a_oe, a_os} !== 12'h000 || {b_ov, b_od, b_oe, b_os} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got a=%h b=%h want 000", {a_ov, a_od, a_oe, a_os}, {b_ov, b_od, b_oe, b_os});
    end
    checks++;
    if (b_ir !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_low got %b want 000", b_ir);
    end
    sv[1][0] = 1'b0;
    s_rst[0] = 1'b0; s_rst[1] = 1'b0;
  endtask

  task automatic test_equal_contention();
    for (int k = 0; k < 4; k++) begin
      sv[0][k] = 1'b1; sd[0][k] = 8'($urandom); se[0][k] = ($urandom_range(0, 1) == 0);
    end
    s_or[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle("contention");
      checks++;
      if (a_ov !== 1'b1 || a_os !== 2'(i % 4)) begin
        errors++;
        $display("FAIL contention_seq beat %0d got v=%b s=%0d want v=1 s=%0d", i, a_ov, a_os, i % 4);
      end
      for (int k = 0; k < 4; k++) begin
        if (!sv[0][k]) begin
          sv[0][k] = 1'b1; sd[0][k] = 8'($urandom); se[0][k] = ($urandom_range(0, 1) == 0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) sv[0][k] = 1'b0;
    s_or[0] = 1'b1;
    cycle("bp_idle");
    sv[0][2] = 1'b1; sd[0][2] = 8'hA5; se[0][2] = 1'b1; s_or[0] = 1'b0;
    cycle("bp_load");
    sv[0][0] = 1'b1; sd[0][0] = 8'h3C; se[0][0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("bp_hold");
      checks++;
      if (a_ir !== 4'b0000 || a_ov !== 1'b1 || a_od !== 8'hA5) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ir=%b v=%b d=%h want ir=0000 v=1 d=a5", i, a_ir, a_ov, a_od);
      end
    end
    s_or[0] = 1'b1;
    cycle("bp_release");
    checks++;
    if (a_ov !== 1'b1 || a_od !== 8'h3C || a_os !== 2'd0) begin
      errors++;
      $display("FAIL bp_release got v=%b d=%h s=%0d want v=1 d=3c s=0", a_ov, a_od, a_os);
    end
    cycle("bp_drain");
  endtask

  task automatic test_sparse();
    s_or[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      se[1][k] = 1'b1; sd[1][k] = 8'(8'h10 + k);
    end
    sv[1][1] = 1'b1;
    cycle("sparse_w1");
    sv[1][0] = 1'b1;
    cycle("sparse_wrap");
    checks++;
    if (b_os !== 2'd0 || b_od !== 8'h10) begin
      errors++;
      $display("FAIL sparse_wrap got s=%0d d=%h want s=0 d=10", b_os, b_od);
    end
    sv[1][0] = 1'b1; sv[1][1] = 1'b1; sv[1][2] = 1'b1;
    cycle("sparse_next");
    checks++;
    if (b_os !== 2'd1) begin
      errors++;
      $display("FAIL sparse_ptr got s=%0d want 1", b_os);
    end
    for (int k = 0; k < 3; k++) sv[1][k] = 1'b0;
    cycle("sparse_idle");
  endtask

  task automatic test_packet_lock();
    s_or[1] = 1'b1;
    sv[1][1] = 1'b1; sd[1][1] = 8'h11; se[1][1] = 1'b0;
    cycle("pkt_beat0");
    sv[1][0] = 1'b1; sd[1][0] = 8'h40; se[1][0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle("pkt_gap");
      checks++;
      if (b_ir[0] !== 1'b0) begin
        errors++;
        $display("FAIL pkt_gap cycle %0d way0 ready got %b want 0", i, b_ir[0]);
      end
    end
    sv[1][1] = 1'b1; sd[1][1] = 8'h12; se[1][1] = 1'b0;
    cycle("pkt_beat1");
    checks++;
    if (b_os !== 2'd1 || b_od !== 8'h12 || b_ir[0] !== 1'b0) begin
      errors++;
      $display("FAIL pkt_beat1 got s=%0d d=%h r0=%b want s=1 d=12 r0=0", b_os, b_od, b_ir[0]);
    end
    sv[1][1] = 1'b1; sd[1][1] = 8'h13; se[1][1] = 1'b1;
    cycle("pkt_last");
    checks++;
    if (b_os !== 2'd1 || b_oe !== 1'b1 || b_ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL pkt_last got s=%0d e=%b r0=%b want s=1 e=1 r0=1", b_os, b_oe, b_ir[0]);
    end
    cycle("pkt_way0");
    checks++;
    if (b_os !== 2'd0 || b_od !== 8'h40) begin
      errors++;
      $display("FAIL pkt_way0 got s=%0d d=%h want s=0 d=40", b_os, b_od);
    end
  endtask

  task automatic test_reset_mid_packet();
    s_or[1] = 1'b1;
    sv[1][1] = 1'b1; sd[1][1] = 8'h21; se[1][1] = 1'b0;
    cycle("rmid_lock");
    sv[1][1] = 1'b1; sd[1][1] = 8'h22; se[1][1] = 1'b0;
    sv[1][0] = 1'b1; sd[1][0] = 8'h50; se[1][0] = 1'b1;
    s_rst[1] = 1'b1;
    drive_all();
    #1;
    checks++;
    if (b_ir !== 3'b000) begin
      errors++;
      $display("FAIL rmid_ready got %b want 000", b_ir);
    end
    cycle("rmid_reset");
    checks++;
    if (b_ov !== 1'b0) begin
      errors++;
      $display("FAIL rmid_discard got v=%b want 0", b_ov);
    end
    s_rst[1] = 1'b0;
    cycle("rmid_rearb");
    checks++;
    if (b_ov !== 1'b1 || b_os !== 2'd0 || b_od !== 8'h50) begin
      errors++;
      $display("FAIL rmid_rearb got v=%b s=%0d d=%h want v=1 s=0 d=50", b_ov, b_os, b_od);
    end
    cycle("rmid_w1");
    for (int k = 0; k < 3; k++) sv[1][k] = 1'b0;
    cycle("rmid_idle");
  endtask

  task automatic test_single_beat();
    s_rst[1] = 1'b1;
    cycle("single_rst");
    s_rst[1] = 1'b0;
    s_or[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k += 2) begin
        if (!sv[1][k]) begin
          sv[1][k] = 1'b1; sd[1][k] = 8'($urandom); se[1][k] = 1'b1;
        end
      end
      cycle("single");
      checks++;
      if (b_os !== 2'((i % 2 == 0) ? 0 : 2)) begin
        errors++;
        $display("FAIL single_alt beat %0d got s=%0d want %0d", i, b_os, (i % 2 == 0) ? 0 : 2);
      end
    end
    for (int k = 0; k < 3; k++) sv[1][k] = 1'b0;
    cycle("single_idle");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 2; w++) begin
        for (int k = 0; k < nw[w]; k++) begin
          if (!sv[w][k] && $urandom_range(0, 2) == 0) begin
            sv[w][k] = 1'b1; sd[w][k] = 8'($urandom); se[w][k] = ($urandom_range(0, 3) == 0);
          end
        end
        s_or[w] = ($urandom_range(0, 3) != 0);
        s_rst[w] = ($urandom_range(0, 63) == 0);
      end
      cycle("random");
    end
    s_rst[0] = 1'b0; s_rst[1] = 1'b0;
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 16; k++) begin
        sv[w][k] = 1'b0; sd[w][k] = 8'h00; se[w][k] = 1'b0;
      end
      last_acc[w] = -1;
    end
    test_reset();
    test_equal_contention();
    test_backpressure();
    test_sparse();
    test_packet_lock();
    test_reset_mid_packet();
    test_single_beat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/base_arrmux.md
# base_arrmux

Round-robin arbiter that shares one valid/ready output stream among `ways` valid/ready requester streams. It forwards one beat per cycle through a single registered output stage. It can optionally hold the grant for a whole packet, delimited by a per-beat end flag. It sits in front of a shared pipeline register chain or downstream consumer, and it carries the winning source index alongside the data.

## Interface
- `ways`, default 2: number of requester streams; legal range 2..16.
- `width`, default 1: data width per beat.
- `pkt`, default 0: 0 = re-arbitrate every beat; 1 = hold the grant until a beat with end flag set is accepted.
- `reset_ready`, default 0: 1 = every `i_r` is forced low while `reset` is high.
- `sw` (local): source index width, `$clog2(ways)`, minimum 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `i_v` input [0:ways-1]: requester valid; bit k belongs to way k.
- `i_r` output [0:ways-1]: requester ready.
- `i_d` input [0:ways*width-1]: way k data occupies bits k*width .. k*width+width-1.
- `i_e` input [0:ways-1]: end-of-packet flag per way. Ignored for arbitration when `pkt`=0, but still forwarded.
- `o_v` output 1: output valid (registered).
- `o_r` input 1: output ready.
- `o_d` output [0:width-1]: output data (registered).
- `o_e` output 1: end flag of the held beat.
- `o_s` output [0:sw-1]: way index of the held beat.

## Operation
- **State:**
  - priority pointer `ptr` (sw bits)
  - `lock` (1 bit) and `lock_id` (sw bits)
  - output holding register {`o_v`, `o_d`, `o_e`, `o_s`}
- **Reset values:** `o_v`=0, `o_d`=0, `o_e`=0, `o_s`=0, `ptr`=0, `lock`=0, `lock_id`=0.
- **Space:** `space` = ~`o_v` | `o_r`, meaning the holding register is empty or draining this cycle.
- **Grant selection (combinational, one-hot or zero):**
  - If `lock`=1: grant way `lock_id` only, whether or not its `i_v` is high. All other ways wait.
  - Otherwise: search ways `ptr`, `ptr`+1, …, wrapping modulo `ways`. Grant the first with `i_v` high; if none, no grant.
- **Ready:** `i_r[k]` = grant[k] & `space` (& ~`reset` when `reset_ready`=1). At most one `i_r` bit is high in any cycle.
- **Accept:** a beat is accepted from way k when `i_v[k]` & `i_r[k]`. On accept, the holding register loads `o_v`=1, `o_d` = way k slice, `o_e` = `i_e[k]`, `o_s` = k.
- **Drain without accept:** when `o_v` & `o_r` and no accept, `o_v` goes to 0. Data fields hold their previous value.
- **Pointer/lock update on accept from way k:**
  - `pkt`=0: `ptr` ← (k+1) mod `ways`; `lock` stays 0.
  - `pkt`=1 and `i_e[k]`=0: `lock` ← 1, `lock_id` ← k; `ptr` unchanged.
  - `pkt`=1 and `i_e[k]`=1: `lock` ← 0; `ptr` ← (k+1) mod `ways`.
  - Single-beat packets (first beat has `i_e` set) never set `lock`.
- **No accept:** `ptr`, `lock` and `lock_id` are unchanged.
- **Wrap-around:** the pointer increments modulo `ways`, including non-power-of-two `ways` (e.g. `ways`=3: 2→0).
- **Reset mid-operation:** a held beat is discarded (`o_v`→0), and any in-progress lock is cleared. A requester mid-packet restarts arbitration as a new packet.

## Timing
- **Latency:** an input beat accepted on edge N appears on `o_v`/`o_d` after edge N. This is 1 cycle of latency.
- **Throughput:** 1 beat per cycle sustained while `o_r`=1. There is no bubble between ways on a grant switch.
- **Paths:** `o_r` → `i_r` is a combinational path. `i_v` → `i_r` is combinational through grant selection. `o_v`/`o_d` have no combinational dependency on inputs.
- **Backpressure:** with `o_v`=1 and `o_r`=0, every `i_r`=0 and the held beat is stable.
- **Same-cycle load and drain:** drain and load in the same cycle are legal. The new beat replaces the drained one.
- **Requester rule:** requesters must hold `i_v`/`i_d`/`i_e` stable until accepted. The block does not check this.

## Test plan
- **Equal contention:** `ways`=4, `pkt`=0, all `i_v`=1, `o_r`=1 from reset → `o_s` sequence 0,1,2,3,0,… one per cycle, starting the cycle after the first accept.
- **Sparse requesters:** `ways`=3, `ptr`=2 after a way-1 accept, only way 0 valid → way 0 granted (wrap 2→0); next `ptr`=1.
- **Backpressure:** `o_r`=0 for 5 cycles with `o_v`=1 and `o_d`=0xA5 → all `i_r`=0 and `o_d` stays 0xA5. `o_r`=1 → 0xA5 consumed, next beat loaded in that same cycle.
- **Packet lock:** `pkt`=1, way 1 sends 3 beats (`i_e`=0,0,1) with a 2-cycle `i_v` gap after beat 1, way 0 continuously valid → way 0 gets no `i_r` until way 1's `i_e`=1 beat is accepted, then way 0 is granted next.
- **Reset mid-packet:** `reset` pulsed for 1 cycle while locked with `o_v`=1 → next cycle `o_v`=0, `lock`=0, `ptr`=0. With `reset_ready`=1, all `i_r`=0 during the reset cycle.
- **Single-beat packets:** `pkt`=1, every beat has `i_e`=1, ways 0 and 2 valid in a 3-way instance → alternating 0,2,0,2, `lock` never set.
